// File: rtl/mixer_decim.sv
// mixer_decim: second-order CIC decimator for the mixer product stream
module mixer_decim #(
  parameter int R = 4,
  parameter int LOG2R = 2,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_valid
);
  localparam int G = W + 2 * LOG2R;
  localparam int S = 2 * LOG2R;
  localparam logic [G:0] HALF = (G + 1)'(1) << (S - 1);
  localparam logic [LOG2R-1:0] LAST = LOG2R'(R - 1);
  logic [G-1:0] int1, int2, c1, d1, d2, y;
  logic [G:0] yr;
  logic [W:0] q;
  logic [W-1:0] sat;
  logic [LOG2R-1:0] phase;
  logic s0, s1;
  logic [1:0] warm;
  // second comb difference, round half up, drop the R^2 gain and clamp to W bits
  always_comb begin
    y = c1 - d2;
    yr = {y[G-1], y} + HALF;
    q = yr[G:S];
    sat = (q[W] != q[W-1]) ? {q[W], {(W - 1){~q[W]}}} : q[W-1:0];
  end
  // integrators and phase on accepted samples; comb strobes run regardless of en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int1 <= '0;
      int2 <= '0;
      c1 <= '0;
      d1 <= '0;
      d2 <= '0;
      phase <= '0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      warm <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (en) begin
        int1 <= int1 + {{S{din[W-1]}}, din};
        int2 <= int2 + int1;
        phase <= (phase == LAST) ? '0 : phase + 1'b1;
      end
      s0 <= en && (phase == LAST);
      s1 <= s0;
      if (s0) begin
        c1 <= int2 - d1;
        d1 <= int2;
      end
      if (s1) begin
        d2 <= c1;
        dout <= sat;
        warm <= warm + {1'b0, ~&warm};
      end
      dout_valid <= s1 && warm[1];
    end
  end
endmodule

// File: tb/tb_mixer_decim.sv
// tb_mixer_decim: random and directed stimulus scored against a triangular-FIR decimator model
module tb_mixer_decim;
  localparam int R = 4;
  localparam int LOG2R = 2;
  localparam int W = 18;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic dout_valid;
  typedef struct {
    longint val;
    bit vld;
    int edge_at;
  } exp_t;
  exp_t q[$];
  longint hist[$];
  int edge_no = 0;
  int total = 0;
  int bad = 0;
  longint last = 0;

  mixer_decim #(.R(R), .LOG2R(LOG2R), .W(W)) dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, edge_no, act, req);
    end
  endtask

  // number of times sample j has been summed into the second integrator after m updates
  function automatic longint f(int m, int j);
    return (m - 1 - j > 0) ? longint'(m - 1 - j) : 0;
  endfunction

  // block n output: triangular FIR (boxcar * boxcar) over the accepted samples, then round/shift/clamp
  function automatic longint ref_out(int n);
    longint y = 0;
    longint hi = (longint'(1) << (W - 1)) - 1;
    longint lo_v = -(longint'(1) << (W - 1));
    int lo = (n - 2) * R - 1;
    if (lo < 0) lo = 0;
    for (int j = lo; j < n * R; j++)
      y += hist[j] * (f(n * R, j) - 2 * f((n - 1) * R, j) + f((n - 2) * R, j));
    y = (y + (longint'(1) << (2 * LOG2R - 1))) >>> (2 * LOG2R);
    return (y > hi) ? hi : (y < lo_v) ? lo_v : y;
  endfunction

  task automatic step(bit e, int v);
    exp_t x;
    en = e;
    din = W'(v);
    @(posedge clk);
    edge_no++;
    if (e) begin
      hist.push_back(longint'(v));
      if (hist.size() % R == 0) begin
        x.val = ref_out(hist.size() / R);
        x.vld = (hist.size() / R) >= 3;
        x.edge_at = edge_no + 2;
        q.push_back(x);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_dout", longint'($signed(dout)), 0);
    chk("rst_valid", longint'(dout_valid), 0);
    q.delete();
    hist.delete();
    step(1'b0, 0);
    step(1'b0, 0);
    reset = 1'b0;
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (reset) last = 0;
      else begin
        if (q.size() > 0 && q[0].edge_at < edge_no) begin
          chk("overdue", edge_no, q[0].edge_at);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].edge_at == edge_no) begin
          x = q.pop_front();
          chk("dout", longint'($signed(dout)), x.val);
          chk("valid", longint'(dout_valid), longint'(x.vld));
        end else begin
          chk("idle_valid", longint'(dout_valid), 0);
          chk("hold", longint'($signed(dout)), last);
        end
        last = longint'($signed(dout));
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    #1;
    chk("init_dout", longint'($signed(dout)), 0);
    chk("init_valid", longint'(dout_valid), 0);
    @(posedge clk);
    #1;
    step(1'b0, 0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b1, 1000);
    do_reset();
    for (int i = 0; i < 4096; i++) step(1'b1, 131071);
    for (int i = 0; i < 4096; i++) step(1'b1, -131072);
    do_reset();
    for (int i = 0; i < 64; i++) step(i[0] == 1'b0, 500);
    for (int i = 0; i < 4; i++) step(1'b1, 500);
    for (int i = 0; i < 6; i++) step(1'b0, 500);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(3, 0) != 0, int'($urandom_range(262143, 0)) - 131072);
    while (hist.size() % R != R - 1) step(1'b1, 777);
    step(1'b1, 777);
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, int'($urandom_range(2000, 0)) - 1000);
    for (int i = 0; i < 8; i++) step(1'b0, 0);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
